// File: rtl/wide_add_seq_pkg.sv
// rtl/wide_add_seq_pkg.sv - shared types and defaults for the wide_add_seq sequencer
package wide_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_N     = 8;
  localparam int DEF_WORDS = 4;

  // Word index needs at least one bit even when WORDS is 1.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// rtl/adder_nbit.sv - N-bit ripple adder slice with carry-in and carry-out
module adder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] total;

  assign total  = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
  assign sum_o  = total[N-1:0];
  assign cout_o = total[N];

endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - W-bit adder time-sharing one N-bit slice, LS word first
// Optional signed-overflow output enabled by defining WIDE_ADD_SEQ_OVF_EN.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic               out_cout,
  output logic               busy
`ifdef WIDE_ADD_SEQ_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;

  adder_nbit #(.N(N)) u_slice (
    .a_i   (a_q[idx_q*N +: N]),
    .b_i   (b_q[idx_q*N +: N]),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*N +: N] <= slice_sum;
          carry_q             <= slice_cout;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LAST) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags come from state only; in_ready is additionally masked by reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

`ifdef WIDE_ADD_SEQ_OVF_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && idx_q == LAST) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq (WORDS=4 and WORDS=1 instances)
module tb_wide_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [2];
  logic        ordy [2];
  logic        cin  [2];
  logic [31:0] ia   [2];
  logic [31:0] ib   [2];

  logic        ir0, ov0, co0, bz0;
  logic        ir1, ov1, co1, bz1;
  logic [31:0] s0;
  logic [7:0]  s1;
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic        ovf0, ovf1;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.N(8), .WORDS(4)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir0), .in_a(ia[0]), .in_b(ib[0]), .in_cin(cin[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out_sum(s0), .out_cout(co0), .busy(bz0)
`ifdef WIDE_ADD_SEQ_OVF_EN
    , .out_ovf(ovf0)
`endif
  );

  wide_add_seq #(.N(8), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir1), .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_cin(cin[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_sum(s1), .out_cout(co1), .busy(bz1)
`ifdef WIDE_ADD_SEQ_OVF_EN
    , .out_ovf(ovf1)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic get_ir(input int s);
    return (s == 1) ? ir1 : ir0;
  endfunction
  function automatic logic get_ov(input int s);
    return (s == 1) ? ov1 : ov0;
  endfunction
  function automatic logic get_bz(input int s);
    return (s == 1) ? bz1 : bz0;
  endfunction
  function automatic logic get_co(input int s);
    return (s == 1) ? co1 : co0;
  endfunction
  function automatic logic [31:0] get_sum(input int s);
    return (s == 1) ? {24'b0, s1} : s0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int s, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input bit stall, output int lat, output logic [31:0] sum,
                       output logic co, output logic ovf);
    int guard;
    guard = 0;
    while (!get_ir(s) && guard < 50) begin step(); guard++; end
    chk("in_ready_wait", get_ir(s), 1);
    ia[s] = a; ib[s] = b; cin[s] = c; iv[s] = 1'b1; ordy[s] = 1'b0;
    step();
    iv[s] = 1'b0;
    chk("busy_after_accept", {get_bz(s), get_ir(s)}, 2'b10);
    lat = 0;
    while (!get_ov(s) && lat < 50) begin step(); lat++; end
    chk("out_valid_wait", get_ov(s), 1);
    guard = 0;
    if (stall) while ($urandom_range(0, 2) != 0 && guard < 20) begin step(); guard++; end
    sum = get_sum(s);
    co  = get_co(s);
`ifdef WIDE_ADD_SEQ_OVF_EN
    ovf = (s == 1) ? ovf1 : ovf0;
`else
    ovf = 1'b0;
`endif
    ordy[s] = 1'b1;
    step();
    ordy[s] = 1'b0;
  endtask

  initial begin
    int          lat;
    int          guard;
    logic [31:0] sum;
    logic        co;
    logic        ovf;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
    vecs[8] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 32'hF0E21567, 1'b0, 1'b0};
    vecs[9] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};

    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b0; cin[s] = 1'b0; ia[s] = '0; ib[s] = '0;
    end

    rst = 1'b1;
    step();
    step();
    chk("reset_flags", {ir0, ov0, bz0, co0}, 4'b0000);
    chk("reset_sum", s0, 0);
    chk("reset_flags_w1", {ir1, ov1, bz1, co1}, 4'b0000);
`ifdef WIDE_ADD_SEQ_OVF_EN
    chk("reset_ovf", ovf0, 0);
`endif
    rst = 1'b0;
    step();
    chk("idle_ready", ir0, 1);

    for (int i = 0; i < 10; i++) begin
      do_op(0, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, lat, sum, co, ovf);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].cout);
`ifdef WIDE_ADD_SEQ_OVF_EN
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
      chk($sformatf("vec%0d_back_idle", i), {ir0, bz0, ov0}, 3'b100);
    end

    // Backpressure: result must hold while new operands are offered and ignored.
    ia[0] = 32'h12345678; ib[0] = 32'h11111111; cin[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b0;
    step();
    ia[0] = 32'hAAAAAAAA; ib[0] = 32'h11111111; cin[0] = 1'b0;
    guard = 0;
    while (!ov0 && guard < 50) begin step(); guard++; end
    chk("bp_out_valid", ov0, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", ir0, 0);
      chk("bp_sum", {co0, s0}, {1'b0, 32'h2345678A});
      step();
    end
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    chk("bp_consumed", {ov0, bz0, ir0}, 3'b001);
    step();
    iv[0] = 1'b0;
    chk("bp_new_accepted", bz0, 1);
    guard = 0;
    while (!ov0 && guard < 50) begin step(); guard++; end
    chk("bp_second_sum", {ov0, co0, s0}, {2'b10, 32'hBBBBBBBB});
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;

    // Reset after two slices have been processed.
    ia[0] = 32'h12345678; ib[0] = 32'h11111111; cin[0] = 1'b1; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrun_reset_flags", {ir0, ov0, bz0, co0}, 4'b0000);
    chk("midrun_reset_sum", s0, 0);
    rst = 1'b0;
    step();
    chk("midrun_reset_idle", {ir0, ov0, bz0}, 3'b100);
    do_op(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, lat, sum, co, ovf);
    chk("after_reset_sum", {co, sum}, {1'b0, 32'h00010000});

    for (int s = 0; s < 2; s++) begin
      int          w;
      logic [63:0] wmask;
      logic [63:0] exp;
      logic [63:0] got;
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      w = (s == 1) ? 8 : 32;
      wmask = (64'd1 << w) - 64'd1;
      for (int k = 0; k < 1000; k++) begin
        a = $urandom();
        b = $urandom();
        c = 1'($urandom_range(0, 1));
        do_op(s, a, b, c, 1'b1, lat, sum, co, ovf);
        exp = ((64'(a) & wmask) + (64'(b) & wmask) + 64'(c)) & ((wmask << 1) | 64'd1);
        got = (64'(co) << w) | (64'(sum) & wmask);
        chk($sformatf("rand_w%0d_%0d", w, k), got, exp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
